// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution datapath.
// Word/address widths, pooling FSM states and the signed-max primitive.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic        [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } pool_state_t;

  // Both operands are signed, so this is a full two's-complement compare.
  function automatic data_t smax(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Holds one row of horizontal pair maxima between even and odd conv rows.
// Synchronous write, combinational read; no reset since contents are rewritten before use.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  data_t         wr_data,
  input  logic [IW-1:0] rd_idx,
  output data_t         rd_data
);

  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/relu_maxpool_writer.sv
// ReLU + 2x2/stride-2 max-pool over a raster conv stream, writing pooled words to SRAM.
// Write appears one cycle after the completing beat; only SRAM writes are never stalled.
module relu_maxpool_writer
  import cnn_pkg::*;
#(
  parameter int OUT_DIM = 14
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  input  addr_t base_addr,
  input  logic  in_valid,
  input  data_t in_data,
  output logic  in_ready,
  output logic  wr_en,
  output addr_t wr_addr,
  output data_t wr_data,
  output logic  busy,
  output logic  done
);

  localparam int HALF = OUT_DIM / 2;
  localparam int CW   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_DIM - 1);

  if (OUT_DIM < 2 || (OUT_DIM % 2) != 0) begin : g_bad_dim
    $error("relu_maxpool_writer: OUT_DIM must be even and >= 2");
  end

  pool_state_t   state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  addr_t         base_reg;
  data_t         hold_reg;

  logic          beat;
  logic [IW-1:0] lb_idx;
  logic          lb_we;
  data_t         lb_rd;
  data_t         hmax;
  data_t         pmax;
  data_t         relu_val;
  addr_t         tile_ofs;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == FIN);
  assign beat     = in_valid && in_ready;

  assign lb_idx   = IW'(col >> 1);
  assign hmax     = smax(hold_reg, in_data);
  assign pmax     = smax(lb_rd, hmax);
  assign relu_val = pmax[DATA_W-1] ? '0 : pmax;
  assign tile_ofs = addr_t'(row >> 1) * addr_t'(HALF) + addr_t'(col >> 1);

  // Even rows park their horizontal maxima; the odd row below completes the window.
  assign lb_we = beat && col[0] && !row[0];

  pool_line_buf #(
    .DEPTH (HALF),
    .IW    (IW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_idx  (lb_idx),
    .wr_data (hmax),
    .rd_idx  (lb_idx),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      base_reg <= '0;
      hold_reg <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_reg <= base_addr;
            row      <= '0;
            col      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            if (!col[0]) begin
              hold_reg <= in_data;
            end else if (row[0]) begin
              wr_en   <= 1'b1;
              wr_data <= relu_val;
              wr_addr <= base_reg + tile_ofs;
            end
            if (col == LAST) begin
              col <= '0;
              if (row == LAST) begin
                state <= DRAIN;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: state <= FIN;
        FIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool_writer.sv
// Scoreboarded bench for relu_maxpool_writer at OUT_DIM=4.
module tb_relu_maxpool_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;

  relu_maxpool_writer #(.OUT_DIM(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [11:0] a;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  logic signed [15:0] pix [16];
  int cycle = 0;
  int last_beat = 0;
  int n_checks = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Every observed write must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%h data=%h at cycle %0d, none expected", wr_addr, wr_data, cycle);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d || cycle !== e.cyc) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                   wr_addr, wr_data, cycle, e.a, e.d, e.cyc);
        end
      end
    end
  end

  // Drive a 4x4 frame from pix; push the reference pooled result for each odd/odd beat.
  task automatic drive_frame(input logic [11:0] base, input bit gaps,
                             input int restart_at, input int stop_after);
    int i = 0;
    int guard = 0;
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (i < 16 && i < stop_after && guard < 300) begin
      guard++;
      if (i == restart_at) begin
        start = 1'b1;
        base_addr = 12'h200;
      end else begin
        start = 1'b0;
      end
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = pix[i];
        if (in_ready === 1'b1) begin
          int r = i / 4;
          int c = i % 4;
          if ((r % 2) == 1 && (c % 2) == 1) begin
            int m = pix[(r-1)*4 + c-1];
            int v;
            exp_t e;
            v = pix[(r-1)*4 + c]; if (v > m) m = v;
            v = pix[r*4 + c-1];   if (v > m) m = v;
            v = pix[r*4 + c];     if (v > m) m = v;
            if (m < 0) m = 0;
            e.a = 12'(int'(base) + (r/2)*2 + c/2);
            e.d = 16'(m);
            e.cyc = cycle + 1;
            q.push_back(e);
          end
          last_beat = cycle;
          i++;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (guard >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_budget: accepted %0d beats, required 16", i);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, wr_en, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready/wr_en/busy/done=%b, want 0000", {in_ready, wr_en, busy, done});
    end
    n_checks++;
    if (wr_addr !== 12'h000 || wr_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h data=%h, want 000/0000", wr_addr, wr_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int k;
    for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
    drive_frame(12'h100, 1'b0, -1, 16);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_drain: in_ready=%b busy=%b, want 0 1", in_ready, busy);
    end
    for (k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || cycle !== last_beat + 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b cyc=%0d busy=%b, want 1 %0d 0", done, cycle, busy, last_beat + 2);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_end: done=%b pending=%0d, want 0 0", done, q.size());
    end
  endtask

  task automatic test_negative();
    int k;
    for (int i = 0; i < 16; i++) pix[i] = -16'sd5;
    drive_frame(12'h040, 1'b0, -1, 16);
    for (k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL neg_done: done=%b pending=%0d, want 1 0", done, q.size());
    end
    pix = '{-16'sd32768, -16'sd1,  -16'sd32768, 16'sd7,
            -16'sd2,     -16'sd3,  -16'sd1,     16'sd0,
            -16'sd32768, -16'sd32768, 16'sd100, -16'sd9,
            -16'sd32768, -16'sd32768, 16'sd3,   16'sd99};
    drive_frame(12'h080, 1'b0, -1, 16);
    for (k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL extreme_done: done=%b pending=%0d, want 1 0", done, q.size());
    end
  endtask

  task automatic test_wrap();
    int k;
    for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
    drive_frame(12'hFFE, 1'b0, -1, 16);
    for (k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_done: done=%b pending=%0d, want 1 0", done, q.size());
    end
  endtask

  task automatic test_gaps();
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_valid: in_ready=%b busy=%b, want 0 0", in_ready, busy);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
    drive_frame(12'h100, 1'b1, -1, 16);
    for (k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || cycle !== last_beat + 2 || q.size() != 0) begin
      n_fail++;
      $display("FAIL gaps_done: done=%b cyc=%0d pending=%0d, want 1 %0d 0", done, cycle, q.size(), last_beat + 2);
    end
  endtask

  task automatic test_start_and_abort();
    int k;
    for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
    drive_frame(12'h100, 1'b0, 6, 9);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: busy=%b wr_en=%b done=%b, want 0 0 0", busy, wr_en, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL post_abort: done=%b busy=%b pending=%0d, want 0 0 0", done, busy, q.size());
    end
    drive_frame(12'h300, 1'b0, -1, 16);
    for (k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rerun_done: done=%b pending=%0d, want 1 0", done, q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    test_reset();
    test_basic();
    test_negative();
    test_wrap();
    test_gaps();
    test_start_and_abort();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
